acc_fp_norm_pipe: RTL and testbench

- Parametrised, pipelined successor to the accumulator-output normaliser.
- Takes an aligned two's-complement accumulator mantissa with its exponent and sign controls.
- Produces a packed {sign, exponent, fraction} float with leading-one normalisation, underflow flush and saturation.
- Sits between the FP accumulator and the writeback stage, with valid/ready handshakes on both sides.

---
 rtl/acc_fp_norm_pipe.sv | 181 ++++++++++++++++++
 tb/tb_acc_fp_norm_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_fp_norm_pipe.sv
// rtl/acc_fp_norm_pipe.sv - two-stage accumulator-to-float normaliser (optional RNE via ACC_FP_NORM_RNE_EN)
module acc_fp_norm_pipe #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 11,
    parameter int ACC_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_sgn,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [ACC_W:0]            in_man,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_result,
    output logic [2:0]                out_flags
);

    localparam int OUT_W = 1 + EXP_W + FRAC_W;
    localparam int LZ_W  = (ACC_W > 1) ? $clog2(ACC_W) : 1;
    // Exponent arithmetic width: wide enough that in_exp - lzc (+1) never wraps.
    localparam int E_W   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
    // Number of norm_ext bits below the kept mantissa (guard + sticky + padding).
    localparam int RND_W = ACC_W - FRAC_W;

    localparam logic [ACC_W-1:0]      ONE_A  = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [E_W-1:0] E_ZERO = '0;
`ifdef ACC_FP_NORM_RNE_EN
    localparam logic signed [E_W-1:0] E_MAX  = E_W'((2 ** EXP_W) - 1);
`endif

    // Handshake control
    logic s1_valid;
    logic s2_valid;
    logic s1_en;
    logic s2_en;

    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid;

    // Stage 1 combinational: magnitude and leading-zero count
    logic [ACC_W-1:0] in_low;
    logic [ACC_W-1:0] mag_c;
    logic [LZ_W-1:0]  lzc_c;

    // Magnitude modulo 2^ACC_W, then find the highest set bit (higher index wins).
    always_comb begin
        in_low = in_man[ACC_W-1:0];
        mag_c  = in_man[ACC_W] ? (~in_low + ONE_A) : in_low;
        lzc_c  = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag_c[i]) begin
                lzc_c = LZ_W'(ACC_W - 1 - i);
            end
        end
    end

    // Stage 1 registers
    logic [ACC_W-1:0] s1_mag;
    logic [LZ_W-1:0]  s1_lzc;
    logic [EXP_W-1:0] s1_exp;
    logic             s1_neg;
    logic [1:0]       s1_sgn;

    // Stage 1 capture: load a new beat whenever stage 1 is free or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mag   <= '0;
            s1_lzc   <= '0;
            s1_exp   <= '0;
            s1_neg   <= 1'b0;
            s1_sgn   <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mag <= mag_c;
                s1_lzc <= lzc_c;
                s1_exp <= in_exp;
                s1_neg <= in_man[ACC_W];
                s1_sgn <= in_sgn;
            end
        end
    end

    // Stage 2 combinational: shift, exponent, sign and special cases
    logic [ACC_W-1:0]      norm_c;
    logic [ACC_W+1:0]      norm_ext_c;
    logic [FRAC_W:0]       m_c;
    logic signed [E_W-1:0] e_c;
    logic                  is_zero_c;
    logic                  sign_c;
    logic [OUT_W-1:0]      res_c;
    logic [2:0]            flags_c;
`ifdef ACC_FP_NORM_RNE_EN
    logic                  guard_c;
    logic                  sticky_c;
    logic                  round_up_c;
    logic [FRAC_W+1:0]     m_r_c;
    logic                  carry_c;
    logic signed [E_W-1:0] e_r_c;
    logic                  unused_rnd;
`else
    logic                  unused_rem;
`endif

    // Normalise the registered magnitude and build the packed float plus flags.
    always_comb begin
        norm_c     = s1_mag << s1_lzc;
        // Two zero pads keep the guard/sticky slices legal when ACC_W == FRAC_W+1.
        norm_ext_c = {norm_c, 2'b00};
        m_c        = norm_ext_c[ACC_W+1 -: FRAC_W+1];
        e_c        = $signed(E_W'(s1_exp)) - $signed(E_W'(s1_lzc));
        is_zero_c  = (s1_mag == '0);
        sign_c     = (is_zero_c && s1_sgn[1]) ? 1'b0 : (s1_sgn[0] ^ s1_neg);
        res_c      = '0;
        flags_c    = '0;
`ifdef ACC_FP_NORM_RNE_EN
        guard_c    = norm_ext_c[RND_W];
        sticky_c   = |norm_ext_c[RND_W-1:0];
        round_up_c = guard_c && (sticky_c || m_c[0]);
        m_r_c      = {1'b0, m_c} + {{(FRAC_W+1){1'b0}}, round_up_c};
        // A carry leaves the fraction bits all zero, i.e. 1.0 at the next exponent.
        carry_c    = m_r_c[FRAC_W+1];
        e_r_c      = e_c + $signed({{(E_W-1){1'b0}}, carry_c});
        unused_rnd = m_r_c[FRAC_W];
        if (is_zero_c) begin
            res_c   = {sign_c, {(EXP_W+FRAC_W){1'b0}}};
            flags_c = 3'b001;
        end else if (e_c <= E_ZERO) begin
            res_c   = '0;
            flags_c = 3'b011;
        end else if (e_r_c > E_MAX) begin
            res_c   = {sign_c, {(EXP_W+FRAC_W){1'b1}}};
            flags_c = 3'b100;
        end else begin
            res_c   = {sign_c, e_r_c[EXP_W-1:0], m_r_c[FRAC_W-1:0]};
            flags_c = 3'b000;
        end
`else
        // Truncation discards the remainder and the implied leading one.
        unused_rem = ^{norm_ext_c[RND_W:0], m_c[FRAC_W]};
        if (is_zero_c) begin
            res_c   = {sign_c, {(EXP_W+FRAC_W){1'b0}}};
            flags_c = 3'b001;
        end else if (e_c <= E_ZERO) begin
            res_c   = '0;
            flags_c = 3'b011;
        end else begin
            res_c   = {sign_c, e_c[EXP_W-1:0], m_c[FRAC_W-1:0]};
            flags_c = 3'b000;
        end
`endif
    end

    // Stage 2 registers
    logic [OUT_W-1:0] s2_result;
    logic [2:0]       s2_flags;

    // Stage 2 capture: hold while the downstream stalls, otherwise take stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= res_c;
                s2_flags  <= flags_c;
            end
        end
    end

    assign out_result = s2_result;
    assign out_flags  = s2_flags;

endmodule

// File: tb/tb_acc_fp_norm_pipe.sv
// tb/tb_acc_fp_norm_pipe.sv - self-checking bench for acc_fp_norm_pipe
module tb_acc_fp_norm_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sgn;
    logic [3:0]  in_exp;
    logic [16:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_flags;

    int vectors     = 0;
    int miscompares = 0;
    int acc_cnt     = 0;
    int out_cnt     = 0;

    logic [18:0] sb[$];
    logic        held_v = 1'b0;
    logic [18:0] held   = '0;

    acc_fp_norm_pipe #(.EXP_W(4), .FRAC_W(11), .ACC_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sgn     (in_sgn),
        .in_exp     (in_exp),
        .in_man     (in_man),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: integer magnitude, doubling until the top bit is set, then pack.
    function automatic logic [18:0] model_out(input logic [16:0] man, input logic [3:0] ex,
                                              input logic [1:0] sg);
        int low, mag, norm, e, m;
`ifdef ACC_FP_NORM_RNE_EN
        int rem;
`endif
        logic sign;
        logic [3:0] e4;
        logic [10:0] f11;
        low = int'(man[15:0]);
        mag = man[16] ? ((65536 - low) % 65536) : low;
        if (mag == 0) begin
            sign = sg[1] ? 1'b0 : (sg[0] ^ man[16]);
            return {3'b001, sign, 15'h0000};
        end
        sign = sg[0] ^ man[16];
        norm = mag;
        e    = int'(ex);
        while (norm < 32768) begin
            norm = norm * 2;
            e    = e - 1;
        end
        if (e <= 0) return {3'b011, 16'h0000};
        m = norm / 16;
`ifdef ACC_FP_NORM_RNE_EN
        rem = norm % 16;
        if (rem > 8 || (rem == 8 && (m % 2) == 1)) m = m + 1;
        if (m == 4096) begin
            m = 2048;
            e = e + 1;
        end
        if (e > 15) return {3'b100, sign, 15'h7FFF};
`endif
        e4  = e[3:0];
        f11 = m[10:0];
        return {3'b000, sign, e4, f11};
    endfunction

    // Scoreboard and hold-stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) check("hold_stable", {13'h0, out_valid, out_flags, out_result}, {13'h0, 1'b1, held});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", {13'h0, out_valid, out_flags, out_result}, 32'h0);
                end else begin
                    check("scoreboard", {13'h0, out_flags, out_result}, {13'h0, sb[0]});
                    void'(sb.pop_front());
                end
                out_cnt++;
            end
            held_v = out_valid && !out_ready;
            held   = {out_flags, out_result};
            if (in_valid && in_ready) begin
                sb.push_back(model_out(in_man, in_exp, in_sgn));
                acc_cnt++;
            end
        end
    end

    // Drive one beat and hold it until accepted (returns after the accepting edge).
    task automatic send_beat(input logic [16:0] man, input logic [3:0] ex, input logic [1:0] sg);
        int n;
        in_valid = 1'b1;
        in_man   = man;
        in_exp   = ex;
        in_sgn   = sg;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Single beat with a literal expectation and a latency check.
    task automatic send_one(input string nm, input logic [16:0] man, input logic [3:0] ex,
                            input logic [1:0] sg, input logic [15:0] xr, input logic [2:0] xf);
        int cyc;
        @(posedge clk);
        #1;
        send_beat(man, ex, sg);
        in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 10);
        check({nm, "_latency"}, 32'(cyc), 32'd2);
        check({nm, "_result"}, {16'h0, out_result}, {16'h0, xr});
        check({nm, "_flags"}, {29'h0, out_flags}, {29'h0, xf});
    endtask

    typedef struct {
        logic [16:0] man;
        logic [3:0]  ex;
        logic [1:0]  sg;
    } beat_t;

    beat_t bp_beats[6];

    initial begin
        int acc0, out0, n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_man    = '0;
        in_exp    = '0;
        in_sgn    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_out_result", {16'h0, out_result}, 32'h0);
        check("reset_out_flags", {29'h0, out_flags}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {31'h0, in_ready}, 32'h1);

        send_one("normalise",  17'h00100, 4'd10, 2'b00, 16'h1800, 3'b000);
        send_one("neg_plain",  17'h1FF00, 4'd12, 2'b00, 16'hA800, 3'b000);
        send_one("neg_flip",   17'h1FF00, 4'd12, 2'b01, 16'h2800, 3'b000);
        send_one("zero_force", 17'h00000, 4'd7,  2'b11, 16'h0000, 3'b001);
        send_one("zero_sign",  17'h00000, 4'd7,  2'b01, 16'h8000, 3'b001);
        send_one("underflow",  17'h00001, 4'd10, 2'b00, 16'h0000, 3'b011);
        send_one("most_neg",   17'h10000, 4'd5,  2'b00, 16'h8000, 3'b001);
`ifdef ACC_FP_NORM_RNE_EN
        send_one("round",      17'h08018, 4'd10, 2'b00, 16'h5002, 3'b000);
        send_one("overflow",   17'h0FFF8, 4'd15, 2'b00, 16'h7FFF, 3'b100);
`else
        send_one("round",      17'h08018, 4'd10, 2'b00, 16'h5001, 3'b000);
        send_one("overflow",   17'h0FFF8, 4'd15, 2'b00, 16'h7FFF, 3'b000);
`endif

        // Backpressure: six back-to-back beats with the sink stalled for four cycles.
        bp_beats[0] = '{17'h00100, 4'd10, 2'b00};
        bp_beats[1] = '{17'h1FF00, 4'd12, 2'b01};
        bp_beats[2] = '{17'h00000, 4'd3,  2'b01};
        bp_beats[3] = '{17'h08018, 4'd10, 2'b00};
        bp_beats[4] = '{17'h0FFF8, 4'd15, 2'b10};
        bp_beats[5] = '{17'h1FFFF, 4'd9,  2'b00};
        @(posedge clk);
        #1;
        acc0      = acc_cnt;
        out0      = out_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_beat(bp_beats[i].man, bp_beats[i].ex, bp_beats[i].sg);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_accepted_before_stall", 32'(acc_cnt - acc0), 32'd2);
                check("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
                @(negedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_drained", 32'(sb.size()), 32'd0);
        check("bp_outputs", 32'(out_cnt - out0), 32'd6);

        // Mid-stream reset with two beats in flight.
        @(posedge clk);
        #1;
        send_beat(17'h00100, 4'd10, 2'b00);
        send_beat(17'h1FF00, 4'd12, 2'b00);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_stale", {31'h0, out_valid}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
